// File: rtl/aurora_hls_nfc_pkg.sv
// Shared constants, state encoding and message helper for the Aurora NFC pause controller.
package aurora_hls_nfc_pkg;

   localparam logic [15:0] NFC_XOFF               = 16'hffff;
   localparam logic [15:0] NFC_XON                = 16'h0000;
   localparam int unsigned REFRESH_CYCLES_DEFAULT = 4096;

   typedef enum logic [1:0] {
      RUN       = 2'd0,
      SEND_XOFF = 2'd1,
      PAUSED    = 2'd2,
      SEND_XON  = 2'd3
   } nfc_state_e;

   // Message carried while a send state is presenting a beat.
   function automatic logic [15:0] nfc_msg(input nfc_state_e st);
      return (st == SEND_XOFF) ? NFC_XOFF : NFC_XON;
   endfunction

endpackage

// File: rtl/aurora_hls_nfc_if.sv
// NFC message channel between the pause controller (master) and the Aurora core (slave).
interface aurora_hls_nfc_if;

   logic        tvalid;
   logic [15:0] tdata;
   logic        tready;

   modport master (output tvalid, output tdata, input tready);
   modport slave  (input tvalid, input tdata, output tready);

endinterface

// File: rtl/aurora_hls_nfc_refresh_timer.sv
// XOFF refresh interval timer: down-counter loaded with CYCLES-1, expires at terminal count zero.
module aurora_hls_nfc_refresh_timer #(
   parameter int unsigned CYCLES = 4096
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam logic [15:0] TC_LOAD = 16'(CYCLES - 1);

   logic [15:0] cnt_q;
   logic [15:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = TC_LOAD;
      end else if (enable && (cnt_q != 16'd0)) begin
         cnt_d = cnt_q - 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= TC_LOAD;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire = enable && !clear && (cnt_q == 16'd0);

endmodule

// File: rtl/aurora_hls_nfc_ctrl.sv
// Aurora native flow control sequencer: sends XOFF/XON on the NFC channel from FIFO watermarks and host pause requests.
// Optional XOFF refresh while paused is enabled by defining AURORA_HLS_NFC_REFRESH_EN.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// RUN       | partner transmitting; watching pause_cond
// SEND_XOFF | presenting 16'hffff until accepted (first or refresh)
// PAUSED    | partner paused; watching resume_cond (and refresh timer)
// SEND_XON  | presenting 16'h0000 until accepted
module aurora_hls_nfc_ctrl
   import aurora_hls_nfc_pkg::*;
#(
   parameter int unsigned REFRESH_CYCLES = REFRESH_CYCLES_DEFAULT,
   parameter int unsigned PAUSE_SRCS     = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  fifo_rx_prog_full,
   input  logic                  fifo_rx_prog_empty,
   input  logic [PAUSE_SRCS-1:0] pause_req,
   input  logic                  s_axi_nfc_tready,
   output logic                  s_axi_nfc_tvalid,
   output logic [15:0]           s_axi_nfc_tdata,
   output logic                  xoff_active,
   output logic [31:0]           xoff_count
);

   if ((REFRESH_CYCLES < 16) || (REFRESH_CYCLES > 65535) ||
       (PAUSE_SRCS < 1) || (PAUSE_SRCS > 8)) begin : g_param_check
      $error("aurora_hls_nfc_ctrl: parameter out of range");
   end

   nfc_state_e  state_q, state_d;
   logic        armed_q, armed_d;
   logic        xoff_active_q, xoff_active_d;
   logic [31:0] xoff_count_q, xoff_count_d;

   logic pause_cond;
   logic resume_cond;
   logic refresh_expire;

   // Full dominates empty, so simultaneous watermarks resolve toward pausing.
   assign pause_cond  = fifo_rx_prog_full | (|pause_req);
   assign resume_cond = fifo_rx_prog_empty & ~(|pause_req) & ~fifo_rx_prog_full;

   assign s_axi_nfc_tvalid = (state_q == SEND_XOFF) || (state_q == SEND_XON);
   assign s_axi_nfc_tdata  = s_axi_nfc_tvalid ? nfc_msg(state_q) : NFC_XON;
   assign xoff_active      = xoff_active_q;
   assign xoff_count       = xoff_count_q;

`ifdef AURORA_HLS_NFC_REFRESH_EN
   aurora_hls_nfc_refresh_timer #(
      .CYCLES (REFRESH_CYCLES)
   ) u_refresh_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (state_q != PAUSED),
      .enable (state_q == PAUSED),
      .expire (refresh_expire)
   );
`else
   assign refresh_expire = 1'b0;
`endif

   // armed_q holds off the first decision for one edge after reset release.
   always_comb begin
      state_d       = state_q;
      armed_d       = 1'b1;
      xoff_active_d = xoff_active_q;
      xoff_count_d  = xoff_count_q;
      unique case (state_q)
         RUN: begin
            if (armed_q && pause_cond) begin
               state_d = SEND_XOFF;
            end
         end
         SEND_XOFF: begin
            if (s_axi_nfc_tready) begin
               state_d       = PAUSED;
               xoff_active_d = 1'b1;
               // A refresh XOFF is recognisable by the partner already being paused.
               if (!xoff_active_q) begin
                  xoff_count_d = xoff_count_q + 32'd1;
               end
            end
         end
         PAUSED: begin
            if (resume_cond) begin
               state_d = SEND_XON;
            end else if (refresh_expire) begin
               state_d = SEND_XOFF;
            end
         end
         SEND_XON: begin
            if (s_axi_nfc_tready) begin
               state_d       = RUN;
               xoff_active_d = 1'b0;
            end
         end
         default: begin
            state_d = RUN;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= RUN;
         armed_q       <= 1'b0;
         xoff_active_q <= 1'b0;
         xoff_count_q  <= '0;
      end else begin
         state_q       <= state_d;
         armed_q       <= armed_d;
         xoff_active_q <= xoff_active_d;
         xoff_count_q  <= xoff_count_d;
      end
   end

endmodule
